// File: rtl/pma_rx_word_aligner.sv
// rtl/pma_rx_word_aligner.sv - PMA receive deserialiser with K28.5 comma alignment and lock FSM
// Optional Bit_Slip input enabled by defining PMA_RX_BIT_SLIP_EN.
module pma_rx_word_aligner #(
    parameter int DATA_WIDTH     = 10,
    parameter int COMMA_LOCK_CNT = 3,
    parameter int MISALIGN_LIMIT = 4
) (
    input  logic                  Recovered_Bit_Clk,
    input  logic                  Rst_n,
    input  logic                  Ser_in,
    input  logic                  RxPolarity,
    input  logic                  Align_En,
`ifdef PMA_RX_BIT_SLIP_EN
    input  logic                  Bit_Slip,
`endif
    output logic [DATA_WIDTH-1:0] Data_out,
    output logic                  Data_valid,
    output logic                  Comma_det,
    output logic                  Aligned
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [9:0]    K28_5_NEG   = 10'h17C;
    localparam logic [9:0]    K28_5_POS   = 10'h283;
    localparam logic [CW-1:0] LAST_BIT    = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] REALIGN_CNT = CW'(10 % DATA_WIDTH);

    typedef enum logic [1:0] {
        UNALIGNED,
        LOCKING,
        LOCKED
    } state_t;

    // Only DATA_WIDTH-1 history bits are kept; the incoming bit completes the word.
    logic [DATA_WIDTH-2:0] history;
    logic [DATA_WIDTH-1:0] shift_next;
    logic [9:0]            window;
    logic [CW-1:0]         bit_cnt;
    logic [CW-1:0]         cnt_next;
    logic [3:0]            lock_cnt;
    logic [3:0]            err_cnt;
    state_t                state;
    logic                  bit_in;
    logic                  comma;
    logic                  in_phase;
    logic                  realign;
    logic                  emit;
    logic                  slip;

    always_comb begin
        bit_in     = Ser_in ^ RxPolarity;
        shift_next = {bit_in, history};
        window     = shift_next[DATA_WIDTH-1 -: 10];
        comma      = (window == K28_5_NEG) || (window == K28_5_POS);
        in_phase   = ((32'(bit_cnt) % 32'd10) == 32'd9);
        realign    = Align_En && comma && !in_phase && (state != LOCKED);
        emit       = (bit_cnt == LAST_BIT) || (realign && (DATA_WIDTH == 10));
`ifdef PMA_RX_BIT_SLIP_EN
        slip       = Bit_Slip && !Align_En;
`else
        slip       = 1'b0;
`endif
        // Emission outranks a slip request, so a slip on the last bit is ignored.
        if (realign)
            cnt_next = REALIGN_CNT;
        else if (emit)
            cnt_next = '0;
        else if (slip)
            cnt_next = bit_cnt;
        else
            cnt_next = bit_cnt + 1'b1;
    end

    always_ff @(posedge Recovered_Bit_Clk) begin
        if (!Rst_n) begin
            history    <= '0;
            bit_cnt    <= '0;
            Data_out   <= '0;
            Data_valid <= 1'b0;
            Comma_det  <= 1'b0;
            Aligned    <= 1'b0;
            state      <= UNALIGNED;
            lock_cnt   <= '0;
            err_cnt    <= '0;
        end else begin
            history    <= shift_next[DATA_WIDTH-1:1];
            bit_cnt    <= cnt_next;
            Data_valid <= emit;
            if (emit) begin
                Data_out  <= shift_next;
                Comma_det <= (shift_next[9:0] == K28_5_NEG) || (shift_next[9:0] == K28_5_POS);
            end else begin
                Comma_det <= 1'b0;
            end

            if (Align_En && comma) begin
                case (state)
                    UNALIGNED: begin
                        lock_cnt <= 4'd1;
                        err_cnt  <= '0;
                        if (COMMA_LOCK_CNT == 1) begin
                            state   <= LOCKED;
                            Aligned <= 1'b1;
                        end else begin
                            state <= LOCKING;
                        end
                    end
                    LOCKING: begin
                        if (in_phase) begin
                            if (lock_cnt + 4'd1 == 4'(COMMA_LOCK_CNT)) begin
                                state   <= LOCKED;
                                Aligned <= 1'b1;
                                err_cnt <= '0;
                            end
                            lock_cnt <= lock_cnt + 4'd1;
                        end else begin
                            lock_cnt <= 4'd1;
                        end
                    end
                    LOCKED: begin
                        if (in_phase) begin
                            err_cnt <= '0;
                        end else if (err_cnt + 4'd1 == 4'(MISALIGN_LIMIT)) begin
                            // Losing lock does not realign on this comma; the next one does.
                            state    <= UNALIGNED;
                            Aligned  <= 1'b0;
                            err_cnt  <= '0;
                            lock_cnt <= '0;
                        end else begin
                            err_cnt <= err_cnt + 4'd1;
                        end
                    end
                    default: begin
                        state   <= UNALIGNED;
                        Aligned <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pma_rx_word_aligner.sv
// tb/tb_pma_rx_word_aligner.sv - directed bench for pma_rx_word_aligner at 10- and 20-bit widths
module tb_pma_rx_word_aligner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        Rst_n, Ser_in, RxPolarity, Align_En;
`ifdef PMA_RX_BIT_SLIP_EN
    logic        Bit_Slip;
`endif
    logic [9:0]  d10;
    logic        v10, c10, a10;
    logic [19:0] d20;
    logic        v20, c20, a20;

    int errors = 0;
    int checks = 0;
    int cd10_pulses = 0;

    int          idx20, nv20;
    int          vidx[3];
    logic [19:0] vdat[3];
    logic        vcd[3];
    logic        val[3];

    pma_rx_word_aligner #(.DATA_WIDTH(10), .COMMA_LOCK_CNT(3), .MISALIGN_LIMIT(4)) dut10 (
        .Recovered_Bit_Clk(clk), .Rst_n(Rst_n), .Ser_in(Ser_in), .RxPolarity(RxPolarity),
        .Align_En(Align_En),
`ifdef PMA_RX_BIT_SLIP_EN
        .Bit_Slip(Bit_Slip),
`endif
        .Data_out(d10), .Data_valid(v10), .Comma_det(c10), .Aligned(a10)
    );

    pma_rx_word_aligner #(.DATA_WIDTH(20), .COMMA_LOCK_CNT(3), .MISALIGN_LIMIT(4)) dut20 (
        .Recovered_Bit_Clk(clk), .Rst_n(Rst_n), .Ser_in(Ser_in), .RxPolarity(RxPolarity),
        .Align_En(Align_En),
`ifdef PMA_RX_BIT_SLIP_EN
        .Bit_Slip(Bit_Slip),
`endif
        .Data_out(d20), .Data_valid(v20), .Comma_det(c20), .Aligned(a20)
    );

    always @(negedge clk) if (c10 === 1'b1) cd10_pulses++;

    // Bits are given in logical (post-polarity) form and pre-inverted on the wire.
    task automatic send_bit(input logic b);
        Ser_in = b ^ RxPolarity;
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [9:0] w);
        for (int i = 0; i < 10; i++) send_bit(w[i]);
    endtask

    task automatic do_reset();
        Rst_n = 1'b0;
        @(posedge clk);
        #1;
        Rst_n = 1'b1;
    endtask

    task automatic send_bit20(input logic b);
        send_bit(b);
        idx20++;
        if (v20 === 1'b1 && nv20 < 3) begin
            vidx[nv20] = idx20;
            vdat[nv20] = d20;
            vcd[nv20]  = c20;
            val[nv20]  = a20;
            nv20++;
        end
    endtask

    task automatic test_reset();
        Rst_n = 1'b0; RxPolarity = 1'b0; Align_En = 1'b1; Ser_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (d10 !== 10'h0) begin errors++; $display("FAIL reset_d10 got=%h exp=000", d10); end
        checks++; if (v10 !== 1'b0) begin errors++; $display("FAIL reset_v10 got=%b exp=0", v10); end
        checks++; if (c10 !== 1'b0) begin errors++; $display("FAIL reset_c10 got=%b exp=0", c10); end
        checks++; if (a10 !== 1'b0) begin errors++; $display("FAIL reset_a10 got=%b exp=0", a10); end
        checks++; if (d20 !== 20'h0) begin errors++; $display("FAIL reset_d20 got=%h exp=00000", d20); end
        checks++; if (v20 !== 1'b0) begin errors++; $display("FAIL reset_v20 got=%b exp=0", v20); end
        Rst_n = 1'b1;
        repeat (5) send_bit(1'b1);
        do_reset();
        checks++; if (v10 !== 1'b0) begin errors++; $display("FAIL midreset_v10 got=%b exp=0", v10); end
        checks++; if (a10 !== 1'b0) begin errors++; $display("FAIL midreset_a10 got=%b exp=0", a10); end
        for (int i = 1; i <= 20; i++) begin
            send_bit(1'b0);
            if (i <= 10) begin
                checks++;
                if (v10 !== (i == 10)) begin errors++; $display("FAIL midreset_v10_bit%0d got=%b exp=%b", i, v10, (i == 10)); end
            end
            if (i == 10) begin
                checks++; if (d10 !== 10'h0) begin errors++; $display("FAIL midreset_d10 got=%h exp=000", d10); end
            end
            checks++;
            if (v20 !== (i == 20)) begin errors++; $display("FAIL midreset_v20_bit%0d got=%b exp=%b", i, v20, (i == 20)); end
        end
    endtask

    task automatic test_comma10(input logic inv, input string tag);
        logic [6:0] pre;
        logic [9:0] kn;
        pre = 7'b1001101;
        kn  = 10'h17C;
        RxPolarity = inv; Align_En = 1'b1;
        do_reset();
        for (int i = 0; i < 7; i++) send_bit(pre[i]);
        for (int i = 0; i < 3; i++) send_bit(kn[i]);
        checks++; if (v10 !== 1'b1 || d10 !== 10'h24D) begin errors++; $display("FAIL %s_w1 got=%b/%h exp=1/24d", tag, v10, d10); end
        checks++; if (c10 !== 1'b0) begin errors++; $display("FAIL %s_w1_cd got=%b exp=0", tag, c10); end
        for (int i = 3; i < 10; i++) send_bit(kn[i]);
        checks++; if (v10 !== 1'b1 || d10 !== 10'h17C) begin errors++; $display("FAIL %s_w2 got=%b/%h exp=1/17c", tag, v10, d10); end
        checks++; if (c10 !== 1'b1 || a10 !== 1'b0) begin errors++; $display("FAIL %s_w2_cd_al got=%b%b exp=10", tag, c10, a10); end
        send_word(10'h283);
        checks++; if (v10 !== 1'b1 || d10 !== 10'h283) begin errors++; $display("FAIL %s_w3 got=%b/%h exp=1/283", tag, v10, d10); end
        checks++; if (c10 !== 1'b1 || a10 !== 1'b0) begin errors++; $display("FAIL %s_w3_cd_al got=%b%b exp=10", tag, c10, a10); end
        send_word(10'h17C);
        checks++; if (d10 !== 10'h17C || c10 !== 1'b1) begin errors++; $display("FAIL %s_w4 got=%h/%b exp=17c/1", tag, d10, c10); end
        checks++; if (a10 !== 1'b1) begin errors++; $display("FAIL %s_w4_aligned got=%b exp=1", tag, a10); end
        send_word(10'h283);
        checks++; if (d10 !== 10'h283 || a10 !== 1'b1) begin errors++; $display("FAIL %s_w5 got=%h/%b exp=283/1", tag, d10, a10); end
    endtask

    task automatic test_misalign();
        int base;
        RxPolarity = 1'b0;
        send_word(10'h155);
        send_word(10'h17C);
        checks++; if (c10 !== 1'b1 || a10 !== 1'b1) begin errors++; $display("FAIL mis_inphase got=%b%b exp=11", c10, a10); end
        send_word(10'h155);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        base = cd10_pulses;
        for (int k = 1; k <= 4; k++) begin
            send_word(10'h17C);
            checks++;
            if (a10 !== (k < 4)) begin errors++; $display("FAIL mis_shift%0d_aligned got=%b exp=%b", k, a10, (k < 4)); end
            send_word(10'h155);
        end
        checks++; if (cd10_pulses !== base) begin errors++; $display("FAIL mis_cd_pulses got=%0d exp=%0d", cd10_pulses, base); end
        send_word(10'h17C);
        checks++; if (v10 !== 1'b1 || d10 !== 10'h17C) begin errors++; $display("FAIL mis_realign got=%b/%h exp=1/17c", v10, d10); end
        checks++; if (c10 !== 1'b1 || a10 !== 1'b0) begin errors++; $display("FAIL mis_realign_cd_al got=%b%b exp=10", c10, a10); end
        send_word(10'h155);
        send_word(10'h17C);
        checks++; if (c10 !== 1'b1 || a10 !== 1'b0) begin errors++; $display("FAIL mis_relock2 got=%b%b exp=10", c10, a10); end
        send_word(10'h155);
        send_word(10'h17C);
        checks++; if (a10 !== 1'b1) begin errors++; $display("FAIL mis_relock3 got=%b exp=1", a10); end
    endtask

    task automatic test_align_dis();
        int base;
        Align_En = 1'b0;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        base = cd10_pulses;
        for (int k = 1; k <= 5; k++) begin
            send_word(10'h155);
            send_word(10'h17C);
            checks++;
            if (a10 !== 1'b1) begin errors++; $display("FAIL dis_frozen%0d got=%b exp=1", k, a10); end
        end
        checks++; if (cd10_pulses !== base) begin errors++; $display("FAIL dis_cd_pulses got=%0d exp=%0d", cd10_pulses, base); end
`ifdef PMA_RX_BIT_SLIP_EN
        begin
            logic [9:0] dw;
            dw = 10'h155;
            for (int i = 0; i < 10; i++) begin
                Bit_Slip = (i < 3);
                send_bit(dw[i]);
            end
            Bit_Slip = 1'b0;
            send_word(10'h17C);
            checks++; if (v10 !== 1'b1 || d10 !== 10'h17C) begin errors++; $display("FAIL slip_word got=%b/%h exp=1/17c", v10, d10); end
            checks++; if (c10 !== 1'b1 || a10 !== 1'b1) begin errors++; $display("FAIL slip_cd_al got=%b%b exp=11", c10, a10); end
        end
`endif
        Align_En = 1'b1;
    endtask

    task automatic test_dw20();
        RxPolarity = 1'b0; Align_En = 1'b1;
        do_reset();
        idx20 = 0; nv20 = 0;
        send_bit20(1'b1); send_bit20(1'b0); send_bit20(1'b1);
        for (int w = 0; w < 3; w++) begin
            logic [9:0] k, d;
            k = 10'h17C;
            d = 10'h155;
            for (int i = 0; i < 10; i++) send_bit20(k[i]);
            for (int i = 0; i < 10; i++) send_bit20(d[i]);
        end
        checks++; if (nv20 !== 3) begin errors++; $display("FAIL dw20_count got=%0d exp=3", nv20); end
        for (int j = 0; j < 3; j++) begin
            if (j < nv20) begin
                checks++; if (vidx[j] !== 23 + 20 * j) begin errors++; $display("FAIL dw20_pos%0d got=%0d exp=%0d", j, vidx[j], 23 + 20 * j); end
                checks++; if (vdat[j] !== 20'h5557C) begin errors++; $display("FAIL dw20_data%0d got=%h exp=5557c", j, vdat[j]); end
                checks++; if (vcd[j] !== 1'b1) begin errors++; $display("FAIL dw20_cd%0d got=%b exp=1", j, vcd[j]); end
            end
        end
        checks++; if (nv20 < 3 || val[0] !== 1'b0 || val[2] !== 1'b1) begin errors++; $display("FAIL dw20_aligned got=%b%b exp=01", val[0], val[2]); end
        checks++; if (a10 !== 1'b1) begin errors++; $display("FAIL dw20_a10_locked got=%b exp=1", a10); end
    endtask

    task automatic test_reset_locked();
        do_reset();
        checks++; if (a10 !== 1'b0 || a20 !== 1'b0) begin errors++; $display("FAIL rstlock_aligned got=%b%b exp=00", a10, a20); end
        checks++; if (v10 !== 1'b0 || v20 !== 1'b0 || c10 !== 1'b0 || c20 !== 1'b0) begin errors++; $display("FAIL rstlock_strobes got=%b%b%b%b exp=0000", v10, v20, c10, c20); end
        checks++; if (d10 !== 10'h0 || d20 !== 20'h0) begin errors++; $display("FAIL rstlock_data got=%h/%h exp=0/0", d10, d20); end
    endtask

    initial begin
`ifdef PMA_RX_BIT_SLIP_EN
        Bit_Slip = 1'b0;
`endif
        test_reset();
        test_comma10(1'b0, "comma10");
        test_comma10(1'b1, "polarity");
        test_misalign();
        test_align_dis();
        test_dw20();
        test_reset_locked();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
